// File: rtl/icetap_jtag_regbank.sv
// icetap JTAG data-register bank: SCAN_N selector, shared DR chain,
// bypass cell for void/out-of-range selections, RO masking, length check.
module icetap_jtag_regbank #(
    parameter int                 SCAN_N_BITS = 3,
    parameter int                 NR_REGS     = 5,
    parameter int                 REG_WIDTH   = 32,
    parameter logic [NR_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           tck,
    input  logic                           reset,
    input  logic                           tdi,
    output logic                           tdo,
    input  logic                           test_logic_reset,
    input  logic                           capture_dr,
    input  logic                           shift_dr,
    input  logic                           update_dr,
    input  logic                           scan_n_ir,
    input  logic                           extest_ir,
    input  logic [NR_REGS*REG_WIDTH-1:0]   capture_data,
    output logic [NR_REGS*REG_WIDTH-1:0]   update_data,
    output logic [NR_REGS-1:0]             capture_strobe,
    output logic [NR_REGS-1:0]             update_strobe,
    output logic [SCAN_N_BITS-1:0]         sel,
    output logic                           len_err
);

    localparam int CW = $clog2(REG_WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(REG_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(REG_WIDTH + 1);

    logic [SCAN_N_BITS-1:0] scan_shift;
    logic [REG_WIDTH-1:0]   shreg;
    logic [CW-1:0]          count;
    logic                   bypass;
    logic [REG_WIDTH-1:0]   cap_word;
    logic [NR_REGS-1:0]     sel_hot;
    logic                   valid;
    logic                   ro_hit;

    // One-hot decode of sel; index 0 and values above NR_REGS decode to none.
    always_comb begin
        cap_word = '0;
        sel_hot  = '0;
        for (int i = 0; i < NR_REGS; i++) begin
            if (sel == SCAN_N_BITS'(i + 1)) begin
                sel_hot[i] = 1'b1;
                cap_word   = capture_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign valid  = extest_ir && (|sel_hot);
    assign ro_hit = |(sel_hot & RO_MASK);

    always_comb begin
        tdo = 1'b0;
        if (scan_n_ir)
            tdo = scan_shift[0];
        else if (valid)
            tdo = shreg[0];
        else if (extest_ir)
            tdo = bypass;
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            sel            <= '0;
            scan_shift     <= '0;
            shreg          <= '0;
            count          <= '0;
            bypass         <= 1'b0;
            update_data    <= '0;
            capture_strobe <= '0;
            update_strobe  <= '0;
            len_err        <= 1'b0;
        end else if (test_logic_reset) begin
            sel            <= '0;
            scan_shift     <= '0;
            shreg          <= '0;
            count          <= '0;
            bypass         <= 1'b0;
            capture_strobe <= '0;
            update_strobe  <= '0;
            len_err        <= 1'b0;
        end else begin
            capture_strobe <= '0;
            update_strobe  <= '0;
            if (scan_n_ir) begin
                if (capture_dr)
                    scan_shift <= sel;
                else if (shift_dr)
                    scan_shift <= {tdi, scan_shift[SCAN_N_BITS-1:1]};
                else if (update_dr)
                    sel <= scan_shift;
            end else if (valid) begin
                if (capture_dr) begin
                    shreg          <= cap_word;
                    count          <= '0;
                    capture_strobe <= sel_hot;
                end else if (shift_dr) begin
                    shreg <= {tdi, shreg[REG_WIDTH-1:1]};
                    if (count != CNT_SAT)
                        count <= count + 1'b1;
                end else if (update_dr && !ro_hit) begin
                    // Read-only registers drop updates without flagging length.
                    if (count != CNT_FULL) begin
                        len_err <= 1'b1;
                    end else begin
                        for (int i = 0; i < NR_REGS; i++) begin
                            if (sel_hot[i])
                                update_data[i*REG_WIDTH +: REG_WIDTH] <= shreg;
                        end
                        update_strobe <= sel_hot;
                    end
                end
            end else if (extest_ir) begin
                if (capture_dr)
                    bypass <= 1'b0;
                else if (shift_dr)
                    bypass <= tdi;
            end
        end
    end

endmodule
